div_ctrl: RTL and testbench
===========================

# div_ctrl

Division sequencer between the CPU execute stage and the 32-bit unsigned non-restoring divider core. It accepts DIV/DIVU requests and converts signed operands to magnitudes. It launches the core, stalls the pipeline until the core finishes, applies sign correction, and writes HI/LO. Divide-by-zero bypasses the core with a fixed result.

## Interface
- No parameters; datapath fixed at 32 bits.
- `clock` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: divide request from execute stage. Sampled only in IDLE.
- `req_signed` in 1: 1 = DIV (two's complement), 0 = DIVU.
- `rs_val` in 32: dividend.
- `rt_val` in 32: divisor.
- `stall` out 1: pipeline hold, combinational.
- `done` out 1: one-cycle pulse; HI/LO updated and valid.
- `hi` out 32: remainder register.
- `lo` out 32: quotient register.
- `core_start` out 1: start pulse to divider core.
- `core_dividend` out 32: magnitude of dividend to core. Registered.
- `core_divisor` out 32: magnitude of divisor to core. Registered.
- `core_q` in 32: core quotient.
- `core_r` in 32: core remainder, already corrected.
- `core_busy` in 1: core busy flag.
- The core's reset is tied to the same `reset` net.

## Operation
- States: IDLE, START, WAIT, FIX.
- **IDLE, `req_valid`=1, `rt_val`≠0:**
  - Latch `neg_q` = `req_signed` & (`rs_val[31]` ^ `rt_val[31]`).
  - Latch `neg_r` = `req_signed` & `rs_val[31]`.
  - Latch `core_dividend`/`core_divisor` = magnitudes. For signed inputs, negate if bit 31 is set; for unsigned inputs, pass unchanged.
  - Go to START.
- **IDLE, `req_valid`=1, `rt_val`=0:**
  - Load raw_q=0xFFFFFFFF and raw_r=`rs_val`; clear `neg_q` and `neg_r`.
  - Go to FIX. `core_start` is never asserted.
- **START:** `core_start`=1 for exactly this cycle; go to WAIT.
- **WAIT:** hold while `core_busy`=1. When `core_busy`=0, latch raw_q=`core_q` and raw_r=`core_r`, then go to FIX.
- **FIX:**
  - `lo` ← `neg_q` ? −raw_q : raw_q.
  - `hi` ← `neg_r` ? −raw_r : raw_r.
  - All arithmetic is modulo 2^32.
  - Go to IDLE; `done`=1 in the following cycle.
- **Magnitude of 0x80000000:** it is 0x80000000, interpreted unsigned. So 0x80000000 / 0xFFFFFFFF signed gives lo=0x80000000, hi=0 with no overflow flag.
- **Remainder sign:** follows the dividend; a zero remainder stays 0.
- **`req_valid` outside IDLE:** ignored. The CPU is stalled, so it holds the request until `done`.
- **Operands:** `rs_val`/`rt_val` are sampled only in the accepting IDLE cycle.

## Timing
- **Reset values:** state=IDLE; `stall`=0, `done`=0, `core_start`=0; `hi`=0, `lo`=0; `core_dividend`=0, `core_divisor`=0.
- `stall` = (`req_valid` & IDLE) | (state≠IDLE). It is low in the `done` cycle, so the instruction retires then.
- Cycle numbering: C0 = the cycle in which `req_valid` is accepted.
- **Normal latency:**
  - C1: START.
  - C2–C33: WAIT with core busy for 32 iterations.
  - C34: WAIT sees `core_busy`=0.
  - C35: FIX.
  - C36: `done`=1.
- **Zero-divisor latency:** C1 FIX, C2 `done`=1.
- **Back-to-back:** a new request may be accepted in the `done` cycle; the new `stall` is then asserted combinationally.
- **Reset mid-operation:** next state is IDLE and `stall`/`done` drop. HI/LO are cleared to 0 and no `done` is issued. The core is reset by the same net, so no stale `core_busy` remains.
- `done` and `core_start` are never high in the same cycle, except `core_start` in the C1 following a `done`-cycle acceptance.

## Test plan
- **DIVU 100/7:** `req_signed`=0 → `core_start` high only at C1; `done` at C36 with lo=14, hi=2; `stall` high C0–C35.
- **DIV −7/2:** `rs_val`=0xFFFFFFF9, `rt_val`=2 → core sees 7/2; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- **DIV 0x80000000/0xFFFFFFFF** → lo=0x80000000, hi=0. **DIVU 0xFFFFFFFF/1** → lo=0xFFFFFFFF, hi=0.
- **Divide-by-zero 5/0, signed and unsigned:**
  - `core_start` never asserted.
  - `done` at C2 with lo=0xFFFFFFFF, hi=5.
  - Repeat with `rs_val`=0xFFFFFFF9 signed → hi=0xFFFFFFF9.
- **Reset at C10 of a 100/7 divide:**
  - `stall` low at C11 and state IDLE.
  - hi=lo=0; no `done`.
  - A fresh 9/3 request afterwards gives lo=3, hi=0 at its C36.
- **Two back-to-back requests, 50/5 then −9/4 signed, second accepted in the first's `done` cycle:**
  - First gives lo=10, hi=0.
  - Second gives lo=0xFFFFFFFE, hi=0xFFFFFFFF, 36 cycles later.
  - `req_valid` toggled during WAIT has no effect.

Source files
------------

// File: rtl/div_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : div_ctrl_if
// Description : Request/response and divider-core signals for div_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface div_ctrl_if;
    // Execute-stage side
    logic        req_valid;
    logic        req_signed;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    // Divider-core side
    logic        core_start;
    logic [31:0] core_dividend;
    logic [31:0] core_divisor;
    logic [31:0] core_q;
    logic [31:0] core_r;
    logic        core_busy;

    modport slave (
        input  req_valid, req_signed, rs_val, rt_val,
        input  core_q, core_r, core_busy,
        output stall, done, hi, lo,
        output core_start, core_dividend, core_divisor
    );

    modport master (
        output req_valid, req_signed, rs_val, rt_val,
        output core_q, core_r, core_busy,
        input  stall, done, hi, lo,
        input  core_start, core_dividend, core_divisor
    );
endinterface
`default_nettype wire

// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : div_ctrl
// Description : DIV/DIVU sequencer: sign handling around an unsigned divider
//               core, pipeline stall and HI/LO write-back.
// Revision    : 1.0 - initial release
// ============================================================================
module div_ctrl (
    input  logic      clock,
    input  logic      reset,
    div_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_FIX   = 2'd3
    } state_t;

    localparam logic [31:0] C_ZERO_DIV_Q = 32'hFFFF_FFFF;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [31:0] r_raw_q;
    logic [31:0] r_raw_r;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;
    logic [31:0] r_core_dividend;
    logic [31:0] r_core_divisor;

    logic        w_idle;
    logic        w_accept;
    logic        w_zero_div;
    logic        w_rs_neg;
    logic        w_rt_neg;
    logic [31:0] w_mag_rs;
    logic [31:0] w_mag_rt;

    assign w_idle     = (r_state == S_IDLE);
    assign w_accept   = bus.req_valid & w_idle;
    assign w_zero_div = (bus.rt_val == 32'd0);
    assign w_rs_neg   = bus.req_signed & bus.rs_val[31];
    assign w_rt_neg   = bus.req_signed & bus.rt_val[31];

    // 0x80000000 negates to itself, which the core reads as the correct magnitude.
    assign w_mag_rs = w_rs_neg ? (32'd0 - bus.rs_val) : bus.rs_val;
    assign w_mag_rt = w_rt_neg ? (32'd0 - bus.rt_val) : bus.rt_val;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_state_nxt = w_zero_div ? S_FIX : S_START;
                end
            end
            S_START: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (!bus.core_busy) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (r_state == S_FIX);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_neg_q         <= 1'b0;
            r_neg_r         <= 1'b0;
            r_raw_q         <= 32'd0;
            r_raw_r         <= 32'd0;
            r_core_dividend <= 32'd0;
            r_core_divisor  <= 32'd0;
        end else if (w_accept) begin
            if (w_zero_div) begin
                r_neg_q <= 1'b0;
                r_neg_r <= 1'b0;
                r_raw_q <= C_ZERO_DIV_Q;
                r_raw_r <= bus.rs_val;
            end else begin
                r_neg_q         <= w_rs_neg ^ w_rt_neg;
                r_neg_r         <= w_rs_neg;
                r_core_dividend <= w_mag_rs;
                r_core_divisor  <= w_mag_rt;
            end
        end else if ((r_state == S_WAIT) && !bus.core_busy) begin
            r_raw_q <= bus.core_q;
            r_raw_r <= bus.core_r;
        end
    end

    // A zero remainder stays zero under negation, so no special case is needed.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (r_state == S_FIX) begin
            r_lo <= r_neg_q ? (32'd0 - r_raw_q) : r_raw_q;
            r_hi <= r_neg_r ? (32'd0 - r_raw_r) : r_raw_r;
        end
    end

    assign bus.stall         = w_accept | ~w_idle;
    assign bus.done          = r_done;
    assign bus.hi            = r_hi;
    assign bus.lo            = r_lo;
    assign bus.core_start    = (r_state == S_START);
    assign bus.core_dividend = r_core_dividend;
    assign bus.core_divisor  = r_core_divisor;

endmodule
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_ctrl
// Description : Self-checking bench for div_ctrl with a 32-iteration core model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_ctrl;

    logic clock;
    logic reset;
    int   n_vec;
    int   n_err;

    div_ctrl_if bus ();

    div_ctrl u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Divider core: busy for 32 cycles after the start pulse, result ready after.
    logic [5:0] core_cnt;
    always @(posedge clock) begin
        if (reset) begin
            bus.core_busy <= 1'b0;
            bus.core_q    <= 32'd0;
            bus.core_r    <= 32'd0;
            core_cnt      <= 6'd0;
        end else if (bus.core_start) begin
            bus.core_busy <= 1'b1;
            core_cnt      <= 6'd31;
            if (bus.core_divisor != 32'd0) begin
                bus.core_q <= bus.core_dividend / bus.core_divisor;
                bus.core_r <= bus.core_dividend % bus.core_divisor;
            end
        end else if (bus.core_busy) begin
            if (core_cnt == 6'd0) bus.core_busy <= 1'b0;
            else                  core_cnt      <= core_cnt - 6'd1;
        end
    end

    // MIPS semantics: truncating division, remainder takes the dividend's sign.
    function automatic void ref_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        longint sa, sb, sq, sr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            sq = sa / sb;
            sr = sa % sb;
            q  = sq[31:0];
            r  = sr[31:0];
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic drive_req(input bit v, input bit s, input logic [31:0] a, input logic [31:0] b);
        bus.req_valid  = v;
        bus.req_signed = s;
        bus.rs_val     = a;
        bus.rt_val     = b;
    endtask

    task automatic run_op(input bit s, input logic [31:0] a, input logic [31:0] b,
                          input bit pre_accepted, input bit toggle,
                          input bit chain, input bit ns, input logic [31:0] na, input logic [31:0] nb);
        logic [31:0] eq, er, emag_a, emag_b;
        int          exp_k, done_k;
        bit          drv_valid, exp_stall;
        ref_div(s, a, b, eq, er);
        exp_k  = (b == 32'd0) ? 2 : 36;
        emag_a = (s && a[31]) ? (32'd0 - a) : a;
        emag_b = (s && b[31]) ? (32'd0 - b) : b;
        done_k = -1;
        if (!pre_accepted) begin
            @(posedge clock); #1;
            drive_req(1'b1, s, a, b);
            #1;
            n_vec++;
            if (bus.stall !== 1'b1) begin
                n_err++;
                $display("FAIL stall_c0 %h/%h: got %b expected 1", a, b, bus.stall);
            end
        end
        for (int k = 1; k <= exp_k; k++) begin
            @(posedge clock); #1;
            if (k == exp_k && chain) begin
                drive_req(1'b1, ns, na, nb);
                drv_valid = 1'b1;
            end else if (toggle && k < exp_k) begin
                drv_valid = 1'($urandom_range(0, 1));
                drive_req(drv_valid, 1'($urandom_range(0, 1)), $urandom, $urandom);
            end else begin
                drive_req(1'b0, 1'b0, 32'd0, 32'd0);
                drv_valid = 1'b0;
            end
            #1;
            exp_stall = (k < exp_k) ? 1'b1 : drv_valid;
            n_vec += 3;
            if (bus.stall !== exp_stall) begin
                n_err++;
                $display("FAIL stall %h/%h k=%0d: got %b expected %b", a, b, k, bus.stall, exp_stall);
            end
            if (bus.core_start !== (k == 1 && b != 32'd0)) begin
                n_err++;
                $display("FAIL core_start %h/%h k=%0d: got %b expected %b", a, b, k,
                         bus.core_start, (k == 1 && b != 32'd0));
            end
            if (bus.done !== (k == exp_k)) begin
                n_err++;
                $display("FAIL done %h/%h k=%0d: got %b expected %b", a, b, k, bus.done, (k == exp_k));
            end
            if (k == 1 && b != 32'd0) begin
                n_vec += 2;
                if (bus.core_dividend !== emag_a) begin
                    n_err++;
                    $display("FAIL core_dividend: got %h expected %h", bus.core_dividend, emag_a);
                end
                if (bus.core_divisor !== emag_b) begin
                    n_err++;
                    $display("FAIL core_divisor: got %h expected %h", bus.core_divisor, emag_b);
                end
            end
            if (bus.done === 1'b1 && done_k < 0) done_k = k;
        end
        n_vec += 3;
        if (done_k != exp_k) begin
            n_err++;
            $display("FAIL done_cycle %h/%h: got %0d expected %0d", a, b, done_k, exp_k);
        end
        if (bus.lo !== eq) begin
            n_err++;
            $display("FAIL lo s=%0d %h/%h: got %h expected %h", s, a, b, bus.lo, eq);
        end
        if (bus.hi !== er) begin
            n_err++;
            $display("FAIL hi s=%0d %h/%h: got %h expected %h", s, a, b, bus.hi, er);
        end
    endtask

    task automatic test_reset;
        drive_req(1'b0, 1'b0, 32'd0, 32'd0);
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #2;
        n_vec += 7;
        if (bus.stall !== 1'b0)        begin n_err++; $display("FAIL rst_stall: got %b expected 0", bus.stall); end
        if (bus.done !== 1'b0)         begin n_err++; $display("FAIL rst_done: got %b expected 0", bus.done); end
        if (bus.core_start !== 1'b0)   begin n_err++; $display("FAIL rst_core_start: got %b expected 0", bus.core_start); end
        if (bus.hi !== 32'd0)          begin n_err++; $display("FAIL rst_hi: got %h expected 0", bus.hi); end
        if (bus.lo !== 32'd0)          begin n_err++; $display("FAIL rst_lo: got %h expected 0", bus.lo); end
        if (bus.core_dividend !== 32'd0) begin n_err++; $display("FAIL rst_dividend: got %h expected 0", bus.core_dividend); end
        if (bus.core_divisor !== 32'd0)  begin n_err++; $display("FAIL rst_divisor: got %h expected 0", bus.core_divisor); end
        reset = 1'b0;
    endtask

    task automatic test_divu;
        run_op(1'b0, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic test_signed;
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        run_op(1'b1, 32'hFFFF_FFF8, 32'd4, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic test_div_zero;
        run_op(1'b0, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        run_op(1'b1, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic test_reset_mid;
        bit seen_done;
        @(posedge clock); #1;
        drive_req(1'b1, 1'b0, 32'd100, 32'd7);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clock); #1;
            drive_req(1'b0, 1'b0, 32'd0, 32'd0);
            if (k == 10) reset = 1'b1;
        end
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        n_vec += 5;
        if (bus.stall !== 1'b0)       begin n_err++; $display("FAIL mid_rst_stall: got %b expected 0", bus.stall); end
        if (bus.done !== 1'b0)        begin n_err++; $display("FAIL mid_rst_done: got %b expected 0", bus.done); end
        if (bus.hi !== 32'd0)         begin n_err++; $display("FAIL mid_rst_hi: got %h expected 0", bus.hi); end
        if (bus.lo !== 32'd0)         begin n_err++; $display("FAIL mid_rst_lo: got %h expected 0", bus.lo); end
        if (bus.core_start !== 1'b0)  begin n_err++; $display("FAIL mid_rst_core_start: got %b expected 0", bus.core_start); end
        seen_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock); #2;
            if (bus.done === 1'b1 || bus.stall === 1'b1) seen_done = 1'b1;
        end
        n_vec++;
        if (seen_done) begin n_err++; $display("FAIL mid_rst_quiet: got activity expected none"); end
        run_op(1'b0, 32'd9, 32'd3, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic test_back_to_back;
        run_op(1'b0, 32'd50, 32'd5, 1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF7, 32'd4);
        run_op(1'b1, 32'hFFFF_FFF7, 32'd4, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random;
        logic [31:0] a, b, na, nb;
        bit          s, ns, chain, chained_in;
        chained_in = 1'b0;
        s = 1'($urandom_range(0, 1));
        a = pick_operand();
        b = pick_operand();
        for (int i = 0; i < 24; i++) begin
            ns    = 1'($urandom_range(0, 1));
            na    = pick_operand();
            nb    = pick_operand();
            chain = (i < 23) && ($urandom_range(0, 2) == 0);
            run_op(s, a, b, chained_in, 1'b1, chain, ns, na, nb);
            chained_in = chain;
            s = ns;
            a = na;
            b = nb;
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        drive_req(1'b0, 1'b0, 32'd0, 32'd0);
        test_reset();
        test_divu();
        test_signed();
        test_div_zero();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
